// File: rtl/osd_text_ctrl.sv
// osd_text_ctrl: character-mode pixel source for the OSD window compositor.
//
// A text RAM holds one character code per 8x8 cell. A font ROM turns
// {char, glyph row} into 8 pixel bits. The display fetch and a host write
// port share the single-port text RAM, and the display fetch has priority.
//
// Optional feature macro: OSD_TEXT_CURSOR_EN. When it is defined, the
// i_cursor_on/i_cursor_addr ports exist and the cursor cell is drawn inverted.
//
// Ports:
//   clk_pixel, rstn        pixel clock, asynchronous active-low reset
//   clk_pixel_ena          pixel-rate enable; the pipeline advances only when high
//   i_active, i_osd_x/y    window-active flag and window-relative coordinates
//   i_wr_valid/o_wr_ready  host write handshake; i_wr_addr/i_wr_data carry the write
//   o_ram_*/i_ram_rdata    text RAM port (read data has 1-clock latency)
//   o_font_addr/i_font_data font ROM port {char, row[2:0]} (1-clock latency)
//   o_osd_en, o_osd_r/g/b  OSD pixel, 3 enabled cycles after the coordinates
//   i_cursor_on/addr       cursor enable and cell address (OSD_TEXT_CURSOR_EN only)
module osd_text_ctrl #(
    parameter int unsigned C_cols      = 32,
    parameter int unsigned C_rows      = 32,
    parameter int unsigned C_addr_bits = 10,
    parameter logic [23:0] C_fg        = 24'hFFFFFF,
    parameter logic [23:0] C_bg        = 24'h000040
) (
    input  logic                   clk_pixel,
    input  logic                   rstn,
    input  logic                   clk_pixel_ena,
    input  logic                   i_active,
    input  logic [9:0]             i_osd_x,
    input  logic [9:0]             i_osd_y,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [C_addr_bits-1:0] i_wr_addr,
    input  logic [7:0]             i_wr_data,
    output logic [C_addr_bits-1:0] o_ram_addr,
    output logic                   o_ram_we,
    output logic [7:0]             o_ram_wdata,
    input  logic [7:0]             i_ram_rdata,
    output logic [10:0]            o_font_addr,
    input  logic [7:0]             i_font_data,
`ifdef OSD_TEXT_CURSOR_EN
    input  logic                   i_cursor_on,
    input  logic [C_addr_bits-1:0] i_cursor_addr,
`endif
    output logic                   o_osd_en,
    output logic [7:0]             o_osd_r,
    output logic [7:0]             o_osd_g,
    output logic [7:0]             o_osd_b
);

    typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [6:0]             w_col;
    logic [6:0]             w_row;
    logic [C_addr_bits-1:0] w_slot_addr;
    logic                   w_blank;
    logic                   w_slot;
    logic                   w_fetch;
    logic                   w_cur_hit;
    logic [7:0]             w_char;

    logic [2:0]             r_yrow;
    logic                   r_blank;
    logic [7:0]             r_char;
    logic                   r_v1;
    logic                   r_v2;
    logic [2:0]             r_act;
    logic                   r_cur0;
    logic                   r_cur1;
    logic [7:0]             r_shift;

    assign w_col       = i_osd_x[9:3];
    assign w_row       = i_osd_y[9:3];
    assign w_slot_addr = C_addr_bits'(w_row) * C_addr_bits'(C_cols) + C_addr_bits'(w_col);
    assign w_blank     = (32'(w_col) >= C_cols) || (32'(w_row) >= C_rows);
    // Gating with rstn keeps every RAM-side output quiet while reset is held.
    assign w_slot      = rstn & clk_pixel_ena & i_active & (i_osd_x[2:0] == 3'd0);
    assign w_fetch     = (r_state == S_IDLE) & w_slot;
    assign w_char      = r_blank ? 8'h20 : i_ram_rdata;

`ifdef OSD_TEXT_CURSOR_EN
    assign w_cur_hit = i_cursor_on & (w_slot_addr == i_cursor_addr);
`else
    assign w_cur_hit = 1'b0;
`endif

    // Arbiter state register.
    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbiter next state and RAM port. The display slot drives the address
    // combinationally so the read data is ready during the RD_WAIT cycle.
    always_comb begin
        w_state_nxt = r_state;
        o_wr_ready  = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_slot) begin
                    w_state_nxt = S_RD_WAIT;
                    o_ram_addr  = w_slot_addr;
                end else begin
                    o_wr_ready = rstn;
                    if (i_wr_valid && rstn) begin
                        o_ram_we    = 1'b1;
                        o_ram_addr  = i_wr_addr;
                        o_ram_wdata = i_wr_data;
                    end
                end
            end
            S_RD_WAIT: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Per-fetch context and the character capture. The capture ignores the
    // enable because the RAM data is only valid in the cycle after the slot.
    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            r_yrow  <= '0;
            r_blank <= 1'b0;
            r_char  <= '0;
            r_cur0  <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_yrow  <= i_osd_y[2:0];
                r_blank <= w_blank;
                r_cur0  <= w_cur_hit;
            end
            if (r_state == S_RD_WAIT) begin
                r_char <= w_char;
            end
        end
    end

    // In the RD_WAIT cycle the captured char is not yet registered, so the
    // font address bypasses straight from the RAM data; after that it is held.
    assign o_font_addr = (r_state == S_RD_WAIT) ? {w_char, r_yrow} : {r_char, r_yrow};

    // Pixel pipeline: slot -> v1 -> v2 (load shift register), active delayed 3.
    always_ff @(posedge clk_pixel or negedge rstn) begin
        if (!rstn) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_act   <= '0;
            r_cur1  <= 1'b0;
            r_shift <= '0;
        end else if (clk_pixel_ena) begin
            r_v1   <= w_fetch;
            r_v2   <= r_v1;
            r_act  <= {r_act[1:0], i_active};
            r_cur1 <= r_cur0;
            if (r_v2) begin
                r_shift <= i_font_data ^ {8{r_cur1}};
            end else begin
                r_shift <= {r_shift[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        o_osd_en = r_act[2];
        {o_osd_r, o_osd_g, o_osd_b} = '0;
        if (r_act[2]) begin
            {o_osd_r, o_osd_g, o_osd_b} = r_shift[7] ? C_fg : C_bg;
        end
    end

endmodule

// File: tb/tb_osd_text_ctrl.sv
module tb_osd_text_ctrl;

    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000040;

    logic        clk_pixel = 1'b0;
    logic        rstn = 1'b0;
    logic        clk_pixel_ena = 1'b0;
    logic        i_active = 1'b0;
    logic [9:0]  i_osd_x = '0;
    logic [9:0]  i_osd_y = '0;
    logic        i_wr_valid = 1'b0;
    logic        o_wr_ready;
    logic [9:0]  i_wr_addr = '0;
    logic [7:0]  i_wr_data = '0;
    logic [9:0]  o_ram_addr;
    logic        o_ram_we;
    logic [7:0]  o_ram_wdata;
    logic [7:0]  i_ram_rdata;
    logic [10:0] o_font_addr;
    logic [7:0]  i_font_data;
    logic        o_osd_en;
    logic [7:0]  o_osd_r, o_osd_g, o_osd_b;
`ifdef OSD_TEXT_CURSOR_EN
    logic        i_cursor_on = 1'b0;
    logic [9:0]  i_cursor_addr = '0;
`endif

    osd_text_ctrl dut (
        .clk_pixel     (clk_pixel),
        .rstn          (rstn),
        .clk_pixel_ena (clk_pixel_ena),
        .i_active      (i_active),
        .i_osd_x       (i_osd_x),
        .i_osd_y       (i_osd_y),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_ram_addr    (o_ram_addr),
        .o_ram_we      (o_ram_we),
        .o_ram_wdata   (o_ram_wdata),
        .i_ram_rdata   (i_ram_rdata),
        .o_font_addr   (o_font_addr),
        .i_font_data   (i_font_data),
`ifdef OSD_TEXT_CURSOR_EN
        .i_cursor_on   (i_cursor_on),
        .i_cursor_addr (i_cursor_addr),
`endif
        .o_osd_en      (o_osd_en),
        .o_osd_r       (o_osd_r),
        .o_osd_g       (o_osd_g),
        .o_osd_b       (o_osd_b)
    );

    always #5 clk_pixel = ~clk_pixel;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        en;
        logic [23:0] rgb;
    } pix_t;

    pix_t       q[$];
    logic       prev_en = 1'b0;
    logic [7:0] mem[1024];
    logic [7:0] shadow[1024];
    bit         mem_ready = 1'b0;

    function automatic logic [7:0] init_pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // Font ROM contents: row 0 of 'A' is 8'h18, everything else a pattern.
    function automatic logic [7:0] font_fn(input logic [10:0] a);
        if (a == 11'h208) return 8'h18;
        return a[10:3] ^ {a[2:0], 5'b10110};
    endfunction

    // Text RAM and font ROM models, both with 1-clock read latency.
    always @(posedge clk_pixel) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_pat(i);
            mem_ready <= 1'b1;
        end else if (o_ram_we) begin
            mem[o_ram_addr] <= o_ram_wdata;
        end
        i_ram_rdata <= mem[o_ram_addr];
        i_font_data <= font_fn(o_font_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pix_t model(input logic a, input logic [9:0] x, input logic [9:0] y);
        pix_t       p;
        int         col, row, lin, idx;
        logic [9:0] ad;
        logic [7:0] c, f;
        p = '0;
        if (!a) return p;
        col = int'(x[9:3]);
        row = int'(y[9:3]);
        lin = row * 32 + col;
        ad  = lin[9:0];
        c   = (col >= 32 || row >= 32) ? 8'h20 : shadow[ad];
        f   = font_fn({c, y[2:0]});
`ifdef OSD_TEXT_CURSOR_EN
        if (i_cursor_on && ad == i_cursor_addr) f = ~f;
`endif
        idx   = 7 - int'(x[2:0]);
        p.en  = 1'b1;
        p.rgb = f[idx] ? FG : BG;
        return p;
    endfunction

    // One clock: compare the output that matures now, then drive and predict.
    task automatic step(input logic a, input logic [9:0] x, input logic [9:0] y, input logic en);
        pix_t e;
        @(negedge clk_pixel);
        if (prev_en && q.size() == 3) begin
            e = q.pop_front();
            chk("pix_en", 32'(o_osd_en), 32'(e.en));
            chk("pix_rgb", 32'({o_osd_r, o_osd_g, o_osd_b}), 32'(e.rgb));
        end
        i_active      = a;
        i_osd_x       = x;
        i_osd_y       = y;
        clk_pixel_ena = en;
        if (en) q.push_back(model(a, x, y));
        prev_en = en;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
        q.delete();
    endtask

    task automatic scan(input logic [9:0] y, input logic [9:0] x0, input int n, input bit rnd_en);
        logic [9:0] x;
        logic       en;
        int         done;
        x    = x0;
        done = 0;
        while (done < n) begin
            en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(1'b1, x, y, en);
            if (en) begin
                x = x + 10'd1;
                done++;
            end
        end
        drain();
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        @(negedge clk_pixel);
        i_active   = 1'b0;
        i_wr_valid = 1'b1;
        i_wr_addr  = a;
        i_wr_data  = d;
        for (int i = 0; i < 16 && !got; i++) begin
            #1;
            if (o_wr_ready) got = 1'b1;
            else @(negedge clk_pixel);
        end
        chk("wr_grant", 32'(got), 32'd1);
        @(posedge clk_pixel);
        #1;
        i_wr_valid = 1'b0;
        if (got) shadow[a] = d;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = init_pat(i);
        clk_pixel_ena = 1'b1;
        repeat (3) @(negedge clk_pixel);
        #1;
        chk("rst_en", 32'(o_osd_en), 32'd0);
        chk("rst_rgb", 32'({o_osd_r, o_osd_g, o_osd_b}), 32'd0);
        chk("rst_we", 32'(o_ram_we), 32'd0);
        chk("rst_ram_addr", 32'(o_ram_addr), 32'd0);
        chk("rst_font_addr", 32'(o_font_addr), 32'd0);
        @(negedge clk_pixel);
        rstn = 1'b1;
        #1;
        chk("ready_after_rst", 32'(o_wr_ready), 32'd1);

        // Host write with the display idle: one clock of we.
        @(negedge clk_pixel);
        i_wr_valid = 1'b1;
        i_wr_addr  = 10'd33;
        i_wr_data  = 8'h41;
        #1;
        chk("wr_we", 32'(o_ram_we), 32'd1);
        chk("wr_addr", 32'(o_ram_addr), 32'd33);
        chk("wr_data", 32'(o_ram_wdata), 32'h41);
        @(posedge clk_pixel);
        #1;
        i_wr_valid = 1'b0;
        shadow[33] = 8'h41;
        #1;
        chk("wr_we_drop", 32'(o_ram_we), 32'd0);

        wr(10'd0, 8'h41);
        wr(10'd1, 8'h42);
        wr(10'd40, 8'h5A);

        // Glyph render, window exit mid-cell, random enable, column overflow.
        scan(10'd0, 10'd0, 32, 1'b0);
        scan(10'd9, 10'd0, 24, 1'b1);
        scan(10'd0, 10'd0, 12, 1'b0);
        scan(10'd0, 10'd248, 16, 1'b0);
        scan(10'd256, 10'd0, 8, 1'b0);

        // Row overflow: blank char and truncated address.
        @(negedge clk_pixel);
        i_active = 1'b1;
        i_osd_x  = 10'd0;
        i_osd_y  = 10'd256;
        #1;
        chk("oor_ram_addr", 32'(o_ram_addr), 32'd0);
        @(negedge clk_pixel);
        i_osd_x = 10'd1;
        #1;
        chk("oor_font_addr", 32'(o_font_addr), 32'h100);
        @(negedge clk_pixel);
        i_active = 1'b0;
        drain();

        // Collision: display slot wins, host waits through RD_WAIT.
        @(negedge clk_pixel);
        i_active   = 1'b1;
        i_osd_x    = 10'd8;
        i_osd_y    = 10'd8;
        i_wr_valid = 1'b1;
        i_wr_addr  = 10'd5;
        i_wr_data  = 8'h33;
        #1;
        chk("col_ready0", 32'(o_wr_ready), 32'd0);
        chk("col_slot_addr", 32'(o_ram_addr), 32'd33);
        chk("col_we0", 32'(o_ram_we), 32'd0);
        @(negedge clk_pixel);
        i_osd_x = 10'd9;
        #1;
        chk("col_ready1", 32'(o_wr_ready), 32'd0);
        chk("col_we1", 32'(o_ram_we), 32'd0);
        @(negedge clk_pixel);
        i_osd_x = 10'd10;
        #1;
        chk("col_ready2", 32'(o_wr_ready), 32'd1);
        chk("col_we2", 32'(o_ram_we), 32'd1);
        chk("col_addr2", 32'(o_ram_addr), 32'd5);
        @(posedge clk_pixel);
        #1;
        i_wr_valid = 1'b0;
        shadow[5]  = 8'h33;
        drain();
        scan(10'd8, 10'd0, 16, 1'b0);
        scan(10'd2, 10'd0, 48, 1'b0);

`ifdef OSD_TEXT_CURSOR_EN
        i_cursor_addr = 10'd0;
        i_cursor_on   = 1'b1;
        scan(10'd0, 10'd0, 16, 1'b0);
        i_cursor_on   = 1'b0;
`endif

        // Reset while pixels are on screen.
        for (int i = 0; i < 5; i++) step(1'b1, 10'(i), 10'd0, 1'b1);
        @(negedge clk_pixel);
        chk("pre_rst_en", 32'(o_osd_en), 32'd1);
        rstn     = 1'b0;
        i_active = 1'b0;
        #1;
        chk("midrst_en", 32'(o_osd_en), 32'd0);
        chk("midrst_rgb", 32'({o_osd_r, o_osd_g, o_osd_b}), 32'd0);
        q.delete();
        prev_en = 1'b0;
        @(negedge clk_pixel);
        rstn = 1'b1;

        // Reset during a host write: the write is lost.
        @(negedge clk_pixel);
        i_wr_valid = 1'b1;
        i_wr_addr  = 10'd7;
        i_wr_data  = 8'h99;
        #1;
        chk("rw_we", 32'(o_ram_we), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rw_we_rst", 32'(o_ram_we), 32'd0);
        @(negedge clk_pixel);
        i_wr_valid = 1'b0;
        rstn       = 1'b1;
        scan(10'd0, 10'd48, 16, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osd_text_ctrl.md
Name: osd_text_ctrl

Overview:
- Character-mode source for the OSD window compositor.
- Converts window-relative pixel coordinates (osd_x/osd_y) into OSD pixel colour and enable via a text RAM and a font ROM.
- Arbitrates the single-port text RAM between the display fetch, which has priority, and a host write port with valid/ready handshake.
- Sits between the host/SPI loader and the OSD compositor inputs i_osd_en/i_osd_r/g/b.

Parameters:
- C_cols, 32, characters per text row (window 256 px / 8).
- C_rows, 32, text rows.
- C_addr_bits, 10, text RAM address width; must satisfy 2^C_addr_bits >= C_cols*C_rows.
- C_fg, 24'hFFFFFF, foreground RGB888.
- C_bg, 24'h000040, background RGB888.

Ports:
- clk_pixel  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- clk_pixel_ena  in  1  pixel-rate enable; pipeline advances only when high
- i_active  in  1  OSD window active (compositor osd_en)
- i_osd_x  in  10  window-relative x
- i_osd_y  in  10  window-relative y
- i_wr_valid  in  1  host write request
- o_wr_ready  out  1  host write grant
- i_wr_addr  in  C_addr_bits  host text address
- i_wr_data  in  8  host character code
- o_ram_addr  out  C_addr_bits  text RAM address
- o_ram_we  out  1  text RAM write enable
- o_ram_wdata  out  8  text RAM write data
- i_ram_rdata  in  8  text RAM read data, 1-clock latency
- o_font_addr  out  11  font ROM address {char, row[2:0]}
- i_font_data  in  8  font row bits, MSB = leftmost pixel; 1-clock latency
- o_osd_en  out  1  OSD pixel valid
- o_osd_r / o_osd_g / o_osd_b  out  8 each  OSD pixel colour

Behaviour:
- Reset (rstn low, asynchronous): arbiter state IDLE, all pipeline valid bits 0, shift register 0, o_osd_en=0, RGB=0, o_ram_we=0, o_ram_addr=0, o_font_addr=0.
- Display slot: enabled cycle (clk_pixel_ena=1) with i_active=1 and i_osd_x[2:0]==0.
- Display slot address: o_ram_addr = (i_osd_y>>3)*C_cols + (i_osd_x>>3), truncated to C_addr_bits. Columns >= C_cols or rows >= C_rows read as blank: char forced to 8'h20.
- Arbiter states:
  - IDLE, on display slot -> RD_WAIT.
  - RD_WAIT: i_ram_rdata captured into char register on the next clk_pixel edge, independent of enable -> IDLE.
- o_wr_ready = (state==IDLE) & ~display_slot. This is combinational, so display wins a simultaneous request.
- Host write: on valid&ready, o_ram_we=1 for exactly that clock, with addr/data taken from the host port. Host holds valid/addr/data until ready. No write is ever issued while a display read is in flight.
- Pixel pipeline, counted in enabled cycles from the slot at phase p=0:
  - p0: RAM read issued.
  - p1: o_font_addr = {char, y[2:0] delayed}.
  - p2: font byte loaded into shift register.
  - p2..p9: shift register shifts left one bit per enabled cycle.
  - Fixed latency of 3 enabled cycles from i_osd_x/i_active to o_osd_en/RGB; i_active is delayed by a matching 3-stage pipe.
- Output: o_osd_en = delayed active. RGB = C_fg when the shifted MSB is 1, else C_bg. When delayed active is 0, RGB=0.
- Window exit mid-cell: the remaining pixels of that cell are suppressed by delayed active. The pipeline flushes without extra cycles.
- clk_pixel_ena low: all pipeline registers hold; arbiter may still grant host writes (state IDLE).
- Reset mid-write: we drops immediately (asynchronous), and the write is lost; the host must retry.

Optional Feature:
- Macro OSD_TEXT_CURSOR_EN.
- Defined: adds inputs i_cursor_on (1) and i_cursor_addr (C_addr_bits). When i_cursor_on=1 and a fetched cell address equals i_cursor_addr, that cell's font bits are inverted. The address is compared at p0 and carried down the pipe.
- Undefined: ports absent; no inversion.

Test Plan:
- Reset: rstn=0 mid-frame with ena=1 -> o_osd_en=0, RGB=0, o_ram_we=0 immediately (asynchronous); after release, o_wr_ready=1 with i_active=0.
- Host write, idle display: i_active=0, write addr=33, data=8'h41 -> o_ram_we high exactly 1 clock, o_ram_addr=33, o_ram_wdata=8'h41.
- Collision: valid at a display slot (x=8, y=8) -> o_wr_ready=0 that cycle and next (RD_WAIT); write completes on the 3rd clock. o_ram_addr=33 at slot.
- Glyph render: RAM[0]=8'h41, font row 0 of 'A'=8'h18, x=0..7, y=0, ena every clock -> 3 cycles later o_osd_en=1, pixels bg,bg,bg,fg,fg,bg,bg,bg.
- Out of range: y=256 (row 32) -> char forced to 8'h20; o_font_addr={8'h20,3'd0}.
- Cursor (macro on): cursor_addr=0, on=1, glyph 8'h18 -> pixels fg,fg,fg,bg,bg,fg,fg,fg.
